interrupt_request_unit: RTL and testbench
=========================================

Name: interrupt_request_unit

Overview:
- Upstream interrupt front end for the multicycle control unit.
- Synchronises raw external interrupt lines and latches rising edges as pending requests.
- Applies a software-written enable mask and picks one request by fixed priority.
- Drives the control unit's InterruptIn and InterruptHandler inputs. It then tracks the acknowledge (EPCWrite) and end-of-service (CLR) signals that the control unit produces.

Parameters:
- NUM_IRQ, 4: number of interrupt lines; must be ≤ 2^HANDLER_W.
- HANDLER_W, 4: width of InterruptHandler.
- SYNC_STAGES, 2: flip-flop stages in each IRQ synchroniser; minimum 2.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- Reset_n  in  1  synchronous active-low reset.
- IRQ  in  NUM_IRQ  raw asynchronous interrupt lines; a rising edge is a request.
- MaskWrite  in  1  when 1, loads MaskData into the enable mask at the clock edge.
- MaskData  in  NUM_IRQ  new enable mask; 1 = enabled.
- EPCWrite  in  1  control unit acknowledge: the interrupt is being taken (EPC saved).
- CLR  in  NUM_IRQ  control unit clear strobes, one bit per line; ends service and/or discards a pending request.
- InterruptIn  out  1  request to the control unit; registered.
- InterruptHandler  out  HANDLER_W  binary index of the selected line, zero-extended; registered.
- Pending  out  NUM_IRQ  pending-request register, for status readback.
- InService  out  1  high while a handler is executing.

Behaviour:
- Reset (Reset_n=0 at a clock edge) clears all of the following: synchronisers, edge history, Pending, mask, state (IDLE), InterruptIn, InterruptHandler, InService.
- After reset every line is masked.
- Synchroniser: each IRQ bit passes through SYNC_STAGES flops. The edge detector compares the last stage with its one-cycle-delayed copy.
- Latency with SYNC_STAGES=2: IRQ first sampled high at edge k → Pending bit set at edge k+2 → InterruptIn=1 after edge k+3, if the line is enabled and the unit is in IDLE.
- Pending[i] next value:
  - set if a rising edge is detected on line i;
  - else cleared if CLR[i]=1, or if line i is acknowledged this cycle;
  - else held.
  - Set beats clear in the same cycle, so a new event is never lost.
- Masking: a disabled line's Pending bit still sets but is not eligible for selection. Re-enabling the line makes it eligible on the next cycle.
- Priority: lowest index wins among lines with Pending & mask set.
- State machine:
  - IDLE: InterruptIn=0, InService=0. If any eligible request exists, latch the winning index into InterruptHandler and go to REQ.
  - REQ: InterruptIn=1. InterruptHandler is held constant even if the mask changes or a higher-priority request arrives; the request is never withdrawn. On EPCWrite=1: clear Pending[handler], go to SERVICE. InterruptIn is 0 from the next cycle.
  - SERVICE: InterruptIn=0, InService=1, no nesting. New edges keep accumulating in Pending. When CLR[handler]=1, go to IDLE.
- If CLR[handler]=1 and EPCWrite=1 in the same REQ cycle, EPCWrite takes precedence and the state goes to SERVICE.
- EPCWrite in IDLE or SERVICE is ignored. CLR bits for other lines only clear their Pending bits.
- A back-to-back request can assert InterruptIn at the earliest 1 cycle after leaving SERVICE (IDLE→REQ takes 1 edge).
- Every selectable index fits in HANDLER_W bits. Upper bits of InterruptHandler are 0.

Test Plan:
- Reset hold: Reset_n=0 for 3 cycles with IRQ=4'b1111 → all outputs 0. After release with mask 0000: Pending=1111 and InterruptIn stays 0.
- Basic flow: mask=1111, pulse IRQ[2] at edge k → Pending=0100 at k+2; InterruptIn=1 and InterruptHandler=2 after k+3. EPCWrite 1 cycle → InterruptIn=0, InService=1, Pending=0000. CLR=0100 → InService=0, state IDLE.
- Priority and hold: IRQ[3] and IRQ[1] rise together → InterruptHandler=1. Raise IRQ[0] while in REQ → handler stays 1. After CLR of line 1, the next request selects line 0, then line 3.
- Masking: mask=0010, pulse IRQ[0] → no InterruptIn, Pending[0]=1. Write mask=0011 → InterruptIn=1 with handler 0 one cycle later.
- Simultaneous set/clear: an edge on line 1 arrives in the same cycle as CLR=0010 → Pending[1] stays 1. EPCWrite and CLR[handler] in the same REQ cycle → SERVICE.
- Reset mid-service: drop Reset_n during SERVICE → next cycle is IDLE with all outputs 0 and Pending cleared. A held-high IRQ does not re-trigger until it falls and rises again.

Source files
------------

// File: rtl/interrupt_request_unit_if.sv
// rtl/interrupt_request_unit_if.sv - interrupt front end <-> control unit signal bundle
interface interrupt_request_unit_if #(
    parameter int NUM_IRQ   = 4,
    parameter int HANDLER_W = 4
);
    logic [NUM_IRQ-1:0]   IRQ;
    logic                 MaskWrite;
    logic [NUM_IRQ-1:0]   MaskData;
    logic                 EPCWrite;
    logic [NUM_IRQ-1:0]   CLR;
    logic                 InterruptIn;
    logic [HANDLER_W-1:0] InterruptHandler;
    logic [NUM_IRQ-1:0]   Pending;
    logic                 InService;

    modport master (
        output IRQ, MaskWrite, MaskData, EPCWrite, CLR,
        input  InterruptIn, InterruptHandler, Pending, InService
    );

    modport slave (
        input  IRQ, MaskWrite, MaskData, EPCWrite, CLR,
        output InterruptIn, InterruptHandler, Pending, InService
    );
endinterface

// File: rtl/interrupt_request_unit.sv
// rtl/interrupt_request_unit.sv - synchronise, latch, mask and prioritise external interrupts
module interrupt_request_unit #(
    parameter int NUM_IRQ     = 4,
    parameter int HANDLER_W   = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic                    CLK,
    input logic                    Reset_n,
    interrupt_request_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t                                state_q;
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0]   sync_q;
    logic [NUM_IRQ-1:0]                    hist_q;
    logic [NUM_IRQ-1:0]                    pending_q;
    logic [NUM_IRQ-1:0]                    pending_d;
    logic [NUM_IRQ-1:0]                    mask_q;
    logic                                  int_in_q;
    logic [HANDLER_W-1:0]                  handler_q;
    logic                                  in_service_q;

    logic [NUM_IRQ-1:0]                    rise;
    logic [NUM_IRQ-1:0]                    eligible;
    logic [NUM_IRQ-1:0]                    handler_sel;
    logic [NUM_IRQ-1:0]                    ack_clr;
    logic [HANDLER_W-1:0]                  win_d;
    logic                                  ack;

    assign rise        = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign eligible    = pending_q & mask_q;
    assign handler_sel = {{(NUM_IRQ-1){1'b0}}, 1'b1} << handler_q;
    assign ack         = (state_q == REQ) && bus.EPCWrite;
    assign ack_clr     = ack ? handler_sel : '0;

    // A freshly detected edge outranks any clear in the same cycle.
    assign pending_d = rise | (pending_q & ~(bus.CLR | ack_clr));

    always_comb begin
        win_d = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_d = HANDLER_W'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            sync_q       <= '0;
            hist_q       <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            state_q      <= IDLE;
            int_in_q     <= 1'b0;
            handler_q    <= '0;
            in_service_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.IRQ};
            hist_q    <= sync_q[SYNC_STAGES-1];
            pending_q <= pending_d;
            if (bus.MaskWrite) begin
                mask_q <= bus.MaskData;
            end
            case (state_q)
                IDLE: begin
                    if (|eligible) begin
                        state_q   <= REQ;
                        int_in_q  <= 1'b1;
                        handler_q <= win_d;
                    end
                end
                REQ: begin
                    if (bus.EPCWrite) begin
                        state_q      <= SERVICE;
                        int_in_q     <= 1'b0;
                        in_service_q <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (|(bus.CLR & handler_sel)) begin
                        state_q      <= IDLE;
                        in_service_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    int_in_q     <= 1'b0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.InterruptIn      = int_in_q;
    assign bus.InterruptHandler = handler_q;
    assign bus.Pending          = pending_q;
    assign bus.InService        = in_service_q;
endmodule

// File: tb/tb_interrupt_request_unit.sv
// tb/tb_interrupt_request_unit.sv - directed self-checking bench for interrupt_request_unit
module tb_interrupt_request_unit;
    logic CLK = 1'b0;
    logic Reset_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    interrupt_request_unit_if #(.NUM_IRQ(4), .HANDLER_W(4)) bus ();

    interrupt_request_unit #(.NUM_IRQ(4), .HANDLER_W(4), .SYNC_STAGES(2)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic write_mask(input logic [3:0] m);
        bus.MaskWrite = 1'b1;
        bus.MaskData  = m;
        tick();
        bus.MaskWrite = 1'b0;
    endtask

    task automatic pulse_clr(input logic [3:0] c);
        bus.CLR = c;
        tick();
        bus.CLR = 4'b0000;
    endtask

    task automatic pulse_ack();
        bus.EPCWrite = 1'b1;
        tick();
        bus.EPCWrite = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic iin, input logic [3:0] hnd,
                              input logic [3:0] pnd, input logic isv);
        check({tag, ".InterruptIn"},      32'(bus.InterruptIn),      32'(iin));
        check({tag, ".InterruptHandler"}, 32'(bus.InterruptHandler), 32'(hnd));
        check({tag, ".Pending"},          32'(bus.Pending),          32'(pnd));
        check({tag, ".InService"},        32'(bus.InService),        32'(isv));
    endtask

    initial begin
        Reset_n       = 1'b0;
        bus.IRQ       = 4'b1111;
        bus.MaskWrite = 1'b0;
        bus.MaskData  = 4'b0000;
        bus.EPCWrite  = 1'b0;
        bus.CLR       = 4'b0000;

        // reset hold, then held-high lines latch but stay masked
        tick(3);
        check_outs("reset", 1'b0, 4'd0, 4'b0000, 1'b0);
        Reset_n = 1'b1;
        tick(3);
        check_outs("post_reset", 1'b0, 4'd0, 4'b1111, 1'b0);
        tick(2);
        check("masked_no_req", 32'(bus.InterruptIn), 32'd0);
        bus.IRQ = 4'b0000;
        pulse_clr(4'b1111);
        check("clr_all", 32'(bus.Pending), 32'h0);
        tick(3);

        // basic flow on line 2
        write_mask(4'b1111);
        bus.IRQ = 4'b0100;
        tick();
        bus.IRQ = 4'b0000;
        tick();
        check("basic_k1_pending", 32'(bus.Pending), 32'h0);
        tick();
        check_outs("basic_k2", 1'b0, 4'd0, 4'b0100, 1'b0);
        tick();
        check_outs("basic_k3", 1'b1, 4'd2, 4'b0100, 1'b0);
        pulse_ack();
        check_outs("basic_ack", 1'b0, 4'd2, 4'b0000, 1'b1);
        pulse_clr(4'b0100);
        check_outs("basic_clr", 1'b0, 4'd2, 4'b0000, 1'b0);
        tick();
        check("basic_idle", 32'(bus.InterruptIn), 32'd0);

        // priority and handler hold
        bus.IRQ = 4'b1010;
        tick();
        bus.IRQ = 4'b0000;
        tick(2);
        check("prio_pending", 32'(bus.Pending), 32'hA);
        tick();
        check_outs("prio_req", 1'b1, 4'd1, 4'b1010, 1'b0);
        bus.IRQ = 4'b0001;
        tick();
        bus.IRQ = 4'b0000;
        tick(3);
        check_outs("prio_hold", 1'b1, 4'd1, 4'b1011, 1'b0);
        pulse_ack();
        check_outs("prio_ack1", 1'b0, 4'd1, 4'b1001, 1'b1);
        pulse_clr(4'b0010);
        check("prio_idle", 32'(bus.InService), 32'd0);
        tick();
        check_outs("prio_next0", 1'b1, 4'd0, 4'b1001, 1'b0);
        pulse_ack();
        pulse_clr(4'b0001);
        tick();
        check_outs("prio_next3", 1'b1, 4'd3, 4'b1000, 1'b0);
        pulse_ack();
        pulse_clr(4'b1000);
        check_outs("prio_done", 1'b0, 4'd3, 4'b0000, 1'b0);

        // masking
        write_mask(4'b0010);
        bus.IRQ = 4'b0001;
        tick();
        bus.IRQ = 4'b0000;
        tick(4);
        check_outs("mask_blocked", 1'b0, 4'd3, 4'b0001, 1'b0);
        write_mask(4'b0011);
        check("mask_write_edge", 32'(bus.InterruptIn), 32'd0);
        tick();
        check_outs("mask_enabled", 1'b1, 4'd0, 4'b0001, 1'b0);
        pulse_ack();
        pulse_clr(4'b0001);

        // set beats clear; ack beats clear in REQ
        bus.IRQ = 4'b0010;
        tick();
        bus.IRQ = 4'b0000;
        tick();
        bus.CLR = 4'b0010;
        tick();
        bus.CLR = 4'b0000;
        check("set_beats_clr", 32'(bus.Pending), 32'h2);
        tick();
        check_outs("sim_req", 1'b1, 4'd1, 4'b0010, 1'b0);
        bus.EPCWrite = 1'b1;
        bus.CLR      = 4'b0010;
        tick();
        bus.EPCWrite = 1'b0;
        bus.CLR      = 4'b0000;
        check_outs("ack_beats_clr", 1'b0, 4'd1, 4'b0000, 1'b1);
        pulse_clr(4'b0010);
        check("sim_idle", 32'(bus.InService), 32'd0);

        // reset during service, held-high line
        write_mask(4'b1111);
        bus.IRQ = 4'b0100;
        tick(4);
        check_outs("rst_req", 1'b1, 4'd2, 4'b0100, 1'b0);
        pulse_ack();
        check("rst_service", 32'(bus.InService), 32'd1);
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        check_outs("rst_mid", 1'b0, 4'd0, 4'b0000, 1'b0);
        tick(3);
        check_outs("rst_relatch", 1'b0, 4'd0, 4'b0100, 1'b0);
        pulse_clr(4'b0100);
        tick(4);
        check("held_no_retrig", 32'(bus.Pending), 32'h0);
        bus.IRQ = 4'b0000;
        tick(3);
        bus.IRQ = 4'b0100;
        tick(3);
        check("retrig_after_fall", 32'(bus.Pending), 32'h4);
        check("retrig_masked", 32'(bus.InterruptIn), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
